// File: rtl/dvp_pattern_tx.sv
// DVP (OV5640-style) camera transmitter driven by an internal RGB565 test-pattern generator.
// Emits vsync/href/data byte pairs (high byte first), one byte per clock.
module dvp_pattern_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 1856,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 984,
    parameter int unsigned VSYNC_LINES = 4,
    parameter int unsigned V_START     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       cam_vsync,
    output logic       cam_href,
    output logic [7:0] cam_data,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_BYTES = 2 * H_TOTAL;
    localparam int unsigned H_CW    = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
    localparam int unsigned V_CW    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned PIX_W   = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [H_CW-1:0]   h_cnt_q, h_cnt_d;
    logic [V_CW-1:0]   v_cnt_q, v_cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [PIX_W-1:0]  solid_q, solid_d;
    logic [BAR_CW-1:0] bar_px_q, bar_px_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              h_last_c;
    logic              v_last_c;
    logic              vsync_c;
    logic              href_c;
    logic [PIX_W-1:0]  x_c;
    logic [PIX_W-1:0]  y_c;
    logic [PIX_W-1:0]  pix_c;
    logic [7:0]        byte_c;

    // Solid colour spreads the upper frame-count bits across R, G and B.
    function automatic logic [PIX_W-1:0] solid_of(input logic [5:0] c);
        return {c[5:1], c, c[5:1]};
    endfunction

    // Eight-entry colour-bar palette, left to right.
    function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
        logic [PIX_W-1:0] col;
        case (idx)
            3'd0:    col = 16'hFFFF;
            3'd1:    col = 16'hFFE0;
            3'd2:    col = 16'h07FF;
            3'd3:    col = 16'h07E0;
            3'd4:    col = 16'hF81F;
            3'd5:    col = 16'hF800;
            3'd6:    col = 16'h001F;
            default: col = 16'h0000;
        endcase
        return col;
    endfunction

    // Timing decode of the current counter position.
    always_comb begin
        h_last_c = (h_cnt_q == H_CW'(H_BYTES - 1));
        v_last_c = (v_cnt_q == V_CW'(V_TOTAL - 1));
        vsync_c  = (32'(v_cnt_q) < VSYNC_LINES);
        href_c   = (32'(v_cnt_q) >= V_START) &&
                   (32'(v_cnt_q) < (V_START + V_ACTIVE)) &&
                   (32'(h_cnt_q) < (2 * H_ACTIVE));
    end

    // Pixel generator: coordinates from the counters, colour from the latched pattern.
    always_comb begin
        x_c = PIX_W'(h_cnt_q >> 1);
        y_c = PIX_W'(v_cnt_q) - PIX_W'(V_START);
        case (sel_q)
            2'd0:    pix_c = bar_colour(bar_idx_q);
            2'd1:    pix_c = x_c;
            2'd2:    pix_c = (((x_c ^ y_c) & 16'h0020) != 16'h0000) ? 16'hFFFF : 16'h0000;
            default: pix_c = solid_q;
        endcase
        byte_c = h_cnt_q[0] ? pix_c[7:0] : pix_c[15:8];
    end

    // Next-state: IDLE/RUN control, raster counters, bar tracker and output decode.
    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        sel_d       = sel_q;
        solid_d     = solid_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        frame_cnt_d = frame_cnt_q;
        vsync_d     = 1'b0;
        href_d      = 1'b0;
        data_d      = 8'h00;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_RUN;
                    h_cnt_d   = '0;
                    v_cnt_d   = '0;
                    sel_d     = pattern_sel;
                    solid_d   = solid_of(frame_cnt_q[7:2]);
                    bar_px_d  = '0;
                    bar_idx_d = '0;
                end
            end
            S_RUN: begin
                vsync_d = vsync_c;
                href_d  = href_c;
                data_d  = href_c ? byte_c : 8'h00;
                if (h_last_c) begin
                    h_cnt_d   = '0;
                    bar_px_d  = '0;
                    bar_idx_d = '0;
                    if (v_last_c) begin
                        // Frame boundary: count it, pick up the new pattern, maybe stop.
                        v_cnt_d     = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        done_d      = 1'b1;
                        sel_d       = pattern_sel;
                        solid_d     = solid_of(frame_cnt_d[7:2]);
                        if (!enable) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + V_CW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + H_CW'(1);
                    // Advance the bar tracker once per pixel (after its low byte).
                    if (h_cnt_q[0]) begin
                        if (bar_px_q == BAR_CW'(BAR_W - 1)) begin
                            bar_px_d  = '0;
                            bar_idx_d = bar_idx_q + 3'd1;
                        end else begin
                            bar_px_d = bar_px_q + BAR_CW'(1);
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            sel_q       <= 2'd0;
            solid_q     <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= 3'd0;
            frame_cnt_q <= 8'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            sel_q       <= sel_d;
            solid_q     <= solid_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
